// File: rtl/argmax_classifier_if.sv
// Score/handshake bundle between the MLP output layer and the argmax classifier.
// ARGMAX_MARGIN_EN adds the best-minus-second-best margin output.
interface argmax_classifier_if #(
  parameter int N_CLASSES = 10,
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 4
);
  logic [N_CLASSES*WIDTH-1:0] scores;
  logic                       start;
  logic                       ack;
  logic                       busy;
  logic                       valid;
  logic [IDX_W-1:0]           class_idx;
  logic [WIDTH-1:0]           max_score;
`ifdef ARGMAX_MARGIN_EN
  logic [WIDTH-1:0]           margin;

  modport master (
    output scores, start, ack,
    input  busy, valid, class_idx, max_score, margin
  );

  modport slave (
    input  scores, start, ack,
    output busy, valid, class_idx, max_score, margin
  );
`else
  modport master (
    output scores, start, ack,
    input  busy, valid, class_idx, max_score
  );

  modport slave (
    input  scores, start, ack,
    output busy, valid, class_idx, max_score
  );
`endif
endinterface

// File: rtl/argmax_classifier.sv
// Serial argmax over N_CLASSES signed scores with a valid/ack result handshake.
// ARGMAX_MARGIN_EN adds second-best tracking and a saturated margin output.
//
// state | meaning
// IDLE  | waiting for start; scores snapshotted on the start edge
// SNAP  | seed best with class 0, point scan at class 1
// SCAN  | one signed compare per cycle; final compare loads the result
// DONE  | result valid, held until ack
module argmax_classifier #(
  parameter int N_CLASSES = 10,
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 4
) (
  input logic clk,
  input logic reset,
  argmax_classifier_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] snap [N_CLASSES];
  logic signed [WIDTH-1:0] best_val, best_val_nxt, cur_val;
  logic [IDX_W-1:0]        best_idx, best_idx_nxt, scan_idx;
  logic [IDX_W-1:0]        class_idx_q;
  logic [WIDTH-1:0]        max_score_q;
  logic                    last_cmp;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]          MARGIN_MAX = {2'b00, {(WIDTH-1){1'b1}}};

  logic signed [WIDTH-1:0] second_val, second_val_nxt;
  logic [WIDTH:0]          margin_diff;
  logic [WIDTH-1:0]        margin_nxt, margin_q;
`endif

  always_comb begin
    cur_val = '0;
    for (int g = 0; g < N_CLASSES; g++) begin
      if (scan_idx == IDX_W'(g)) cur_val = snap[g];
    end
  end

  assign last_cmp = (scan_idx == LAST_IDX);

  // Strictly greater only, so the lowest index keeps a tie.
  always_comb begin
    best_val_nxt = best_val;
    best_idx_nxt = best_idx;
    if (cur_val > best_val) begin
      best_val_nxt = cur_val;
      best_idx_nxt = scan_idx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  always_comb begin
    second_val_nxt = second_val;
    if (cur_val > best_val) begin
      second_val_nxt = best_val;
    end else if (cur_val > second_val) begin
      second_val_nxt = cur_val;
    end
    // best >= second always holds, so the difference is non-negative.
    margin_diff = {best_val_nxt[WIDTH-1], best_val_nxt} -
                  {second_val_nxt[WIDTH-1], second_val_nxt};
    margin_nxt  = (margin_diff > MARGIN_MAX) ? MARGIN_MAX[WIDTH-1:0]
                                             : margin_diff[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SNAP;
      SNAP:    state_nxt = SCAN;
      SCAN:    if (last_cmp) state_nxt = DONE;
      DONE:    if (bus.ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < N_CLASSES; g++) snap[g] <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      scan_idx    <= '0;
      class_idx_q <= '0;
      max_score_q <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_val  <= '0;
      margin_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int g = 0; g < N_CLASSES; g++) snap[g] <= bus.scores[g*WIDTH +: WIDTH];
          end
        end
        SNAP: begin
          best_val   <= snap[0];
          best_idx   <= '0;
          scan_idx   <= IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
          second_val <= MOST_NEG;
`endif
        end
        SCAN: begin
          best_val <= best_val_nxt;
          best_idx <= best_idx_nxt;
          scan_idx <= scan_idx + 1'b1;
`ifdef ARGMAX_MARGIN_EN
          second_val <= second_val_nxt;
`endif
          if (last_cmp) begin
            class_idx_q <= best_idx_nxt;
            max_score_q <= best_val_nxt;
`ifdef ARGMAX_MARGIN_EN
            margin_q    <= margin_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = (state == DONE);
  assign bus.class_idx = class_idx_q;
  assign bus.max_score = max_score_q;
`ifdef ARGMAX_MARGIN_EN
  assign bus.margin    = margin_q;
`endif

endmodule
